ula_muldiv: RTL and testbench

- Parametrised multi-cycle multiply/divide unit that extends the combinational ULA with MIPS MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Owns the HI/LO architectural registers.
- Sits beside the ULA in the EX stage. The control unit launches an operation with a start pulse and stalls on busy.
- MFHI/MFLO read the hi/lo outputs directly.

---
 rtl/ula_muldiv_pkg.sv | 17 +
 rtl/ula_muldiv_step.sv | 30 +++
 rtl/ula_muldiv.sv | 122 ++++++++++++
 tb/tb_ula_muldiv.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ula_muldiv_pkg.sv
// rtl/ula_muldiv_pkg.sv - operation codes and FSM encoding for the multiply/divide unit
package ula_muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/ula_muldiv_step.sv
// rtl/ula_muldiv_step.sv - one shift-add or one restoring-subtract iteration
module ula_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 mode_div_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opnd_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  // acc holds {partial, multiplier} when multiplying and {remainder, dividend/quotient} when dividing
  always_comb begin
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    diff   = rem_sh[WIDTH-1:0] - opnd_i;
    if (mode_div_i) begin
      if (rem_sh >= {1'b0, opnd_i})
        acc_o = {diff, acc_i[WIDTH-2:0], 1'b1};
      else
        acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end else begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ula_muldiv.sv
// rtl/ula_muldiv.sv - multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
module ula_muldiv
  import ula_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               div_q, qneg_q, rneg_q, done_q, dz_q;
  logic [WIDTH-1:0]   opb_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] acc_q, acc_step, prod;
  logic               idle, launch, write_mt, op_signed, a_neg, b_neg, fix_wr;
  logic [WIDTH-1:0]   a_mag, b_mag, fix_hi, fix_lo;

  assign idle      = (state_q == MD_IDLE);
  assign launch    = idle && start && !flush && (op <= MD_DIVU);
  assign write_mt  = idle && start && !flush && ((op == MD_MTHI) || (op == MD_MTLO));
  assign op_signed = (op == MD_MULT) || (op == MD_DIV);
  assign a_neg     = op_signed && In1[WIDTH-1];
  assign b_neg     = op_signed && In2[WIDTH-1];
  assign a_mag     = a_neg ? -In1 : In1;
  assign b_mag     = b_neg ? -In2 : In2;
  assign fix_wr    = (state_q == MD_FIX) && !flush;

  ula_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_div_i (div_q),
    .acc_i      (acc_q),
    .opnd_i     (opb_q),
    .acc_o      (acc_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MD_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (launch) state_d = MD_CALC;
      MD_CALC: begin
        if (flush)                   state_d = MD_IDLE;
        else if (cnt_q == CNT_W'(1)) state_d = MD_FIX;
      end
      MD_FIX:  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != MD_IDLE);
  end

  // A zero divisor subtracts nothing, so the remainder half ends up holding the dividend magnitude
  always_comb begin
    prod   = qneg_q ? -acc_q : acc_q;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (div_q) begin
      fix_hi = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      fix_lo = (opb_q == '0) ? '1 : (qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      div_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      opb_q  <= '0;
      acc_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= fix_wr;
      if (launch) begin
        cnt_q  <= CNT_W'(WIDTH);
        div_q  <= op[1];
        qneg_q <= a_neg ^ b_neg;
        rneg_q <= a_neg;
        opb_q  <= b_mag;
        acc_q  <= {{WIDTH{1'b0}}, a_mag};
      end else if (state_q == MD_CALC) begin
        cnt_q  <= cnt_q - CNT_W'(1);
        acc_q  <= acc_step;
      end
      if (fix_wr) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
        if (div_q) dz_q <= (opb_q == '0);
      end
      if (write_mt) begin
        if (op == MD_MTHI) hi_q <= In1;
        else               lo_q <= In1;
      end
    end
  end

  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_ula_muldiv.sv
// tb/tb_ula_muldiv.sv - directed vector bench for ula_muldiv at WIDTH 32, 8 and 16
module tb_ula_muldiv;
  import ula_muldiv_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        st32 = 1'b0, st8 = 1'b0, st16 = 1'b0;
  logic [2:0]  op_r = 3'd0;
  logic [63:0] a_r = '0, b_r = '0;

  logic        busy32, done32, dz32, busy8, done8, dz8, busy16, done16, dz16;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;
  logic [15:0] hi16, lo16;

  int          sel = 0;
  logic        c_busy, c_done, c_dz;
  logic [63:0] c_hi, c_lo;
  int          n_vec = 0, n_fail = 0;

  ula_muldiv #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .start(st32), .op(op_r),
    .In1(a_r[31:0]), .In2(b_r[31:0]), .flush(flush), .busy(busy32), .done(done32),
    .div_zero(dz32), .hi(hi32), .lo(lo32));
  ula_muldiv #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(st8), .op(op_r),
    .In1(a_r[7:0]), .In2(b_r[7:0]), .flush(flush), .busy(busy8), .done(done8),
    .div_zero(dz8), .hi(hi8), .lo(lo8));
  ula_muldiv #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .start(st16), .op(op_r),
    .In1(a_r[15:0]), .In2(b_r[15:0]), .flush(flush), .busy(busy16), .done(done16),
    .div_zero(dz16), .hi(hi16), .lo(lo16));

  always #5 clk = ~clk;

  always_comb begin
    case (sel)
      1: begin c_busy = busy8;  c_done = done8;  c_dz = dz8;  c_hi = {56'b0, hi8};  c_lo = {56'b0, lo8};  end
      2: begin c_busy = busy16; c_done = done16; c_dz = dz16; c_hi = {48'b0, hi16}; c_lo = {48'b0, lo16}; end
      default: begin c_busy = busy32; c_done = done32; c_dz = dz32; c_hi = {32'b0, hi32}; c_lo = {32'b0, lo32}; end
    endcase
  end

  typedef struct {
    int          sel;
    logic [2:0]  op;
    logic [63:0] a, b, hi, lo;
    logic        dz;
    int          bc;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input int s, input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                        output int bc, output int dn);
    bit fin;
    sel = s;
    @(negedge clk);
    op_r = o; a_r = a; b_r = b;
    case (s)
      1:       st8  = 1'b1;
      2:       st16 = 1'b1;
      default: st32 = 1'b1;
    endcase
    @(negedge clk);
    st32 = 1'b0; st8 = 1'b0; st16 = 1'b0;
    bc = 0; dn = 0; fin = 1'b0;
    for (int i = 0; i < 200 && !fin; i++) begin
      if (c_busy) bc++;
      if (c_done) dn++;
      if (!c_busy) fin = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    if (c_done) dn++;
  endtask

  int bc, dn, cnt;

  initial begin
    tv.push_back('{0, MD_MULTU, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 64'h1,        1'b0, 33});
    tv.push_back('{0, MD_MULT,  64'hFFFFFFF9, 64'h3,        64'hFFFFFFFF, 64'hFFFFFFEB, 1'b0, 33});
    tv.push_back('{0, MD_DIV,   64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF, 64'hFFFFFFFD, 1'b0, 33});
    tv.push_back('{0, MD_DIVU,  64'h7,        64'h2,        64'h1,        64'h3,        1'b0, 33});
    tv.push_back('{0, MD_DIVU,  64'h1234,     64'h0,        64'h1234,     64'hFFFFFFFF, 1'b1, 33});
    tv.push_back('{0, MD_DIV,   64'h80000000, 64'hFFFFFFFF, 64'h0,        64'h80000000, 1'b0, 33});
    tv.push_back('{0, MD_MULT,  64'h80000000, 64'h80000000, 64'h40000000, 64'h0,        1'b0, 33});
    tv.push_back('{0, MD_DIV,   64'h7,        64'hFFFFFFFE, 64'h1,        64'hFFFFFFFD, 1'b0, 33});
    tv.push_back('{0, MD_DIV,   64'hFFFFFFF8, 64'h0,        64'hFFFFFFF8, 64'hFFFFFFFF, 1'b1, 33});
    tv.push_back('{0, MD_MULT,  64'h0,        64'h5,        64'h0,        64'h0,        1'b1, 33});
    tv.push_back('{0, MD_MULTU, 64'h12345678, 64'h10,       64'h1,        64'h23456780, 1'b1, 33});
    tv.push_back('{0, MD_DIVU,  64'd100,      64'd7,        64'd2,        64'd14,       1'b0, 33});
    tv.push_back('{1, MD_MULTU, 64'hFF,       64'hFF,       64'hFE,       64'h01,       1'b0, 9});
    tv.push_back('{1, MD_MULT,  64'hF9,       64'h03,       64'hFF,       64'hEB,       1'b0, 9});
    tv.push_back('{2, MD_MULTU, 64'hFFFF,     64'hFFFF,     64'hFFFE,     64'h0001,     1'b0, 17});
    tv.push_back('{2, MD_MULT,  64'hFFF9,     64'h0003,     64'hFFFF,     64'hFFEB,     1'b0, 17});

    repeat (3) @(negedge clk);
    chk("reset busy", {63'b0, busy32}, 64'h0);
    chk("reset done", {63'b0, done32}, 64'h0);
    chk("reset dz",   {63'b0, dz32},   64'h0);
    chk("reset hi",   {32'b0, hi32},   64'h0);
    chk("reset lo",   {32'b0, lo32},   64'h0);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      run_op(tv[i].sel, tv[i].op, tv[i].a, tv[i].b, bc, dn);
      chk($sformatf("v%0d hi", i),   c_hi, tv[i].hi);
      chk($sformatf("v%0d lo", i),   c_lo, tv[i].lo);
      chk($sformatf("v%0d dz", i),   {63'b0, c_dz}, {63'b0, tv[i].dz});
      chk($sformatf("v%0d busy cycles", i), 64'(bc), 64'(tv[i].bc));
      chk($sformatf("v%0d done pulses", i), 64'(dn), 64'd1);
    end

    // MTHI/MTLO write in one edge without going busy
    sel = 0;
    @(negedge clk); op_r = MD_MTHI; a_r = 64'hA5A5A5A5; st32 = 1'b1;
    @(negedge clk); st32 = 1'b0;
    chk("mthi hi",   {32'b0, hi32}, 64'hA5A5A5A5);
    chk("mthi lo",   {32'b0, lo32}, 64'd14);
    chk("mthi busy", {63'b0, busy32}, 64'h0);
    chk("mthi done", {63'b0, done32}, 64'h0);
    @(negedge clk); op_r = MD_MTLO; a_r = 64'h5A5A5A5A; st32 = 1'b1;
    @(negedge clk); st32 = 1'b0;
    chk("mtlo lo", {32'b0, lo32}, 64'h5A5A5A5A);

    // start while busy is ignored
    @(negedge clk); op_r = MD_MULT; a_r = 64'd3; b_r = 64'd5; st32 = 1'b1;
    @(negedge clk); st32 = 1'b0;
    repeat (5) @(negedge clk);
    op_r = MD_MTLO; a_r = 64'hDEADBEEF; b_r = 64'h7; st32 = 1'b1;
    @(negedge clk); st32 = 1'b0;
    repeat (40) @(negedge clk);
    chk("busy-start lo", {32'b0, lo32}, 64'd15);
    chk("busy-start hi", {32'b0, hi32}, 64'd0);

    // flush at cycle 10 of a DIV
    @(negedge clk); op_r = MD_DIVU; a_r = 64'd100; b_r = 64'd7; st32 = 1'b1;
    @(negedge clk); st32 = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre-flush busy", {63'b0, busy32}, 64'h1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flush busy", {63'b0, busy32}, 64'h0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done32) cnt++;
      @(negedge clk);
    end
    chk("flush done", 64'(cnt), 64'd0);
    chk("flush hi", {32'b0, hi32}, 64'd0);
    chk("flush lo", {32'b0, lo32}, 64'd15);

    // flush beats start in IDLE
    @(negedge clk); op_r = MD_MTHI; a_r = 64'h11111111; st32 = 1'b1; flush = 1'b1;
    @(negedge clk); st32 = 1'b0; flush = 1'b0;
    chk("flush+start hi",   {32'b0, hi32}, 64'd0);
    chk("flush+start busy", {63'b0, busy32}, 64'h0);

    // set div_zero, then reset mid-CALC
    run_op(0, MD_DIVU, 64'd5, 64'd0, bc, dn);
    chk("dz before reset", {63'b0, dz32}, 64'h1);
    @(negedge clk); op_r = MD_MULT; a_r = 64'd3; b_r = 64'd5; st32 = 1'b1;
    @(negedge clk); st32 = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst busy", {63'b0, busy32}, 64'h0);
    chk("rst done", {63'b0, done32}, 64'h0);
    chk("rst dz",   {63'b0, dz32},   64'h0);
    chk("rst hi",   {32'b0, hi32},   64'h0);
    chk("rst lo",   {32'b0, lo32},   64'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
